buzzer_tone_gen: RTL and testbench
==================================

BUZZER_TONE_GEN -- requirements
Module: buzzer_tone_gen

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, giving the input clock frequency in Hz.
REQ-002 The block SHALL have parameter F_MIN_HZ, default 100, giving the tone frequency for sel_i=0.
REQ-003 The block SHALL have parameter F_STEP_HZ, default 100, giving the tone frequency increment per sel_i step.
REQ-004 The block SHALL have parameter SEL_W, default 4, giving the selector width.
REQ-005 The block SHALL have parameter CNT_W, default 22, giving the half-period compare width.
REQ-006 The block SHALL have parameter BCD_DIGITS, default 5, giving the number of BCD digits.
REQ-007 The block SHALL derive FREQ_W = $clog2(F_MIN_HZ+(2**SEL_W-1)*F_STEP_HZ+1) locally.
REQ-008 The block SHALL have ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- sel_i  in  SEL_W  tone selector.
- en_i  in  1  tone enable.
- buzzer_o  out  1  square-wave drive.
- cmp_freq_o  out  CNT_W  half-period in clocks.
- freq_hz_o  out  FREQ_W  applied frequency, binary.
- freq_bcd_o  out  BCD_DIGITS x 4  applied frequency, BCD, digit 0 = units.
- busy_o  out  1  computation in progress.
- upd_o  out  1  one-cycle pulse on output update.

Function
REQ-009 Target frequency SHALL be f = F_MIN_HZ + sel*F_STEP_HZ, computed in FREQ_W bits.
REQ-010 The FSM SHALL have states IDLE, DIV, BCD and DONE.
REQ-011 In IDLE, a start SHALL occur when init_pending=1 or sel_i differs from the last applied selector; sel_i SHALL be captured at that edge, and init_pending SHALL be cleared.
REQ-012 DIV SHALL run a restoring divider, CLK_HZ (32-bit) / (2*f), one quotient bit per cycle, for exactly 32 cycles; the quotient SHALL be truncated.
REQ-013 A quotient of 2**CNT_W or more SHALL saturate to 2**CNT_W-1.
REQ-014 BCD SHALL run double-dabble on f, one bit per cycle, for exactly FREQ_W cycles.
REQ-015 DONE SHALL last one cycle, load cmp_freq_o, freq_hz_o and freq_bcd_o atomically, and return to IDLE.
REQ-016 upd_o SHALL be high in the first cycle the new values are visible, exactly 33+FREQ_W cycles after the capture edge (44 cycles at default parameters).
REQ-017 busy_o SHALL be 1 in DIV and BCD and 0 otherwise.
REQ-018 sel_i changes during DIV, BCD or DONE SHALL NOT disturb the computation in progress; they SHALL be evaluated in IDLE on the next cycle.
REQ-019 The tone counter SHALL be CNT_W bits; with en_i=1 and cmp_freq_o>=1 it SHALL increment each cycle, and on reaching max(cmp_freq_o,1)-1 it SHALL wrap to 0 and toggle buzzer_o.
REQ-020 When en_i=0 or cmp_freq_o=0, the counter SHALL be held at 0 and buzzer_o at 0 from the next edge.
REQ-021 On the upd_o edge, the counter and buzzer_o SHALL restart from 0.

Reset
REQ-022 Asserting reset SHALL asynchronously force buzzer_o=0, cmp_freq_o=0, freq_hz_o=0, freq_bcd_o=0, busy_o=0 and upd_o=0, and set state=IDLE and init_pending=1.
REQ-023 Reset asserted mid-DIV or mid-BCD SHALL abandon the computation, and no upd_o SHALL follow.
REQ-024 After reset release, a computation for the current sel_i SHALL start automatically.

Configuration
REQ-025 With macro BUZZER_MUTE_EN defined, an input port mute_i (1 bit) SHALL exist; mute_i=1 SHALL force buzzer_o=0 while the counter keeps running, and release SHALL resume with the counter's current phase.
REQ-026 Without BUZZER_MUTE_EN, the mute_i port SHALL be absent, and behaviour SHALL be exactly REQ-019..021.

Verification
REQ-027 Release reset with sel_i=0 and en_i=1 -> upd_o pulse 44 cycles later; cmp_freq_o=250000, freq_hz_o=100, freq_bcd_o=0x00100; buzzer_o toggles every 250000 cycles.
REQ-028 Set sel_i=15 -> cmp_freq_o=15625, freq_bcd_o=0x01600, busy_o high for 43 cycles, buzzer_o period 31250 cycles.
REQ-029 Set sel_i=5, then sel_i=9 ten cycles later (mid-DIV) -> first upd_o gives 41666/0x00600, and a second upd_o gives 25000/0x01000.
REQ-030 Drop en_i mid-tone -> buzzer_o=0 and counter=0 next cycle; re-raise en_i -> first toggle after cmp_freq_o cycles.
REQ-031 Assert reset at DIV cycle 10 -> all outputs return to reset values and there is no stale upd_o; after release, a fresh computation produces correct values.
REQ-032 With BUZZER_MUTE_EN defined and sel_i=15, mute_i=1 for 50000 cycles -> buzzer_o=0 throughout; after release, toggles stay aligned to the unmuted 15625-cycle grid.

Source files
------------

// File: rtl/buzzer_tone_gen.sv
// Square-wave buzzer: selector -> frequency -> half-period (serial divider) and BCD readout (double-dabble).
// Latency: outputs update 33+FREQ_W cycles after a selector capture; upd_o marks the first visible cycle.
// No backpressure: selector changes while busy are held off and picked up in IDLE. Optional BUZZER_MUTE_EN adds mute_i.
module buzzer_tone_gen #(
  parameter int CLK_HZ     = 50000000,
  parameter int F_MIN_HZ   = 100,
  parameter int F_STEP_HZ  = 100,
  parameter int SEL_W      = 4,
  parameter int CNT_W      = 22,
  parameter int BCD_DIGITS = 5,
  localparam int FREQ_W    = $clog2(F_MIN_HZ + (2**SEL_W - 1) * F_STEP_HZ + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [SEL_W-1:0]          sel_i,
  input  logic                      en_i,
`ifdef BUZZER_MUTE_EN
  input  logic                      mute_i,
`endif
  output logic                      buzzer_o,
  output logic [CNT_W-1:0]          cmp_freq_o,
  output logic [FREQ_W-1:0]         freq_hz_o,
  output logic [BCD_DIGITS*4-1:0]   freq_bcd_o,
  output logic                      busy_o,
  output logic                      upd_o
);

  localparam int STEP_W = 6;
  localparam int BCD_W  = BCD_DIGITS * 4;

  typedef enum logic [1:0] {IDLE, DIV, BCD, DONE} state_t;

  state_t              state_q, state_d;
  logic                init_pend_q, init_pend_d;
  logic [SEL_W-1:0]    last_sel_q, last_sel_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic [FREQ_W:0]     div_q, div_d;
  logic [31:0]         dvd_q, dvd_d;
  logic [31:0]         rem_q, rem_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [FREQ_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]    cmp_q, cmp_d;
  logic [FREQ_W-1:0]   hz_q, hz_d;
  logic [BCD_W-1:0]    bcdo_q, bcdo_d;
  logic                upd_q, upd_d;
  logic [CNT_W-1:0]    tone_cnt_q, tone_cnt_d;
  logic                buzz_q, buzz_d;

  logic [FREQ_W-1:0]   f_calc;
  logic [32:0]         rem_sh;
  logic [31:0]         rem_sub;
  logic                rem_ge;
  logic [BCD_W-1:0]    bcd_adj;
  logic [CNT_W-1:0]    quo_sat;

  // Target frequency for the current selector, truncated to FREQ_W bits.
  always_comb begin
    f_calc = FREQ_W'(F_MIN_HZ) + FREQ_W'(F_STEP_HZ) * FREQ_W'(sel_i);
  end

  // One restoring-division step and one double-dabble step, plus quotient saturation.
  always_comb begin
    rem_sh  = {rem_q, dvd_q[31]};
    rem_ge  = (rem_sh >= 33'(div_q));
    rem_sub = rem_sh[31:0] - 32'(div_q);
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
    // The divider keeps its quotient in the dividend register once all 32 bits are shifted.
    if (|(dvd_q >> CNT_W)) begin
      quo_sat = '1;
    end else begin
      quo_sat = dvd_q[CNT_W-1:0];
    end
  end

  // Control FSM: capture, 32 divide steps, FREQ_W BCD steps, atomic output load.
  always_comb begin
    state_d     = state_q;
    init_pend_d = init_pend_q;
    last_sel_d  = last_sel_q;
    freq_d      = freq_q;
    div_d       = div_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    step_d      = step_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cmp_d       = cmp_q;
    hz_d        = hz_q;
    bcdo_d      = bcdo_q;
    upd_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (init_pend_q || (sel_i != last_sel_q)) begin
          state_d     = DIV;
          init_pend_d = 1'b0;
          last_sel_d  = sel_i;
          freq_d      = f_calc;
          div_d       = {f_calc, 1'b0};
          dvd_d       = 32'(CLK_HZ);
          rem_d       = '0;
          step_d      = '0;
          bin_d       = f_calc;
          bcd_d       = '0;
        end
      end
      DIV: begin
        rem_d  = rem_ge ? rem_sub : rem_sh[31:0];
        dvd_d  = {dvd_q[30:0], rem_ge};
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(31)) begin
          state_d = BCD;
          step_d  = '0;
        end
      end
      BCD: begin
        bcd_d  = (bcd_adj << 1) | BCD_W'(bin_q[FREQ_W-1]);
        bin_d  = bin_q << 1;
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(FREQ_W - 1)) begin
          state_d = DONE;
          step_d  = '0;
        end
      end
      DONE: begin
        cmp_d   = quo_sat;
        hz_d    = freq_q;
        bcdo_d  = bcd_q;
        upd_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tone counter: wraps at cmp-1 and toggles the drive; restarts in phase with each update.
  always_comb begin
    tone_cnt_d = tone_cnt_q;
    buzz_d     = buzz_q;
    if (state_q == DONE) begin
      tone_cnt_d = '0;
      buzz_d     = 1'b0;
    end else if (!en_i || (cmp_q == '0)) begin
      tone_cnt_d = '0;
      buzz_d     = 1'b0;
    end else if (tone_cnt_q == (cmp_q - CNT_W'(1))) begin
      tone_cnt_d = '0;
      buzz_d     = ~buzz_q;
    end else begin
      tone_cnt_d = tone_cnt_q + CNT_W'(1);
    end
  end

  // State and datapath registers; reset abandons any computation in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      init_pend_q <= 1'b1;
      last_sel_q  <= '0;
      freq_q      <= '0;
      div_q       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      step_q      <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      cmp_q       <= '0;
      hz_q        <= '0;
      bcdo_q      <= '0;
      upd_q       <= 1'b0;
      tone_cnt_q  <= '0;
      buzz_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_pend_q <= init_pend_d;
      last_sel_q  <= last_sel_d;
      freq_q      <= freq_d;
      div_q       <= div_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      step_q      <= step_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cmp_q       <= cmp_d;
      hz_q        <= hz_d;
      bcdo_q      <= bcdo_d;
      upd_q       <= upd_d;
      tone_cnt_q  <= tone_cnt_d;
      buzz_q      <= buzz_d;
    end
  end

  assign cmp_freq_o = cmp_q;
  assign freq_hz_o  = hz_q;
  assign freq_bcd_o = bcdo_q;
  assign upd_o      = upd_q;
  assign busy_o     = (state_q == DIV) || (state_q == BCD);

`ifdef BUZZER_MUTE_EN
  // Mute only gates the pin; the counter phase keeps running underneath.
  assign buzzer_o = buzz_q & ~mute_i;
`else
  assign buzzer_o = buzz_q;
`endif

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Bench for buzzer_tone_gen at default parameters: selector table, mid-computation
// selector change, reset abort, no-recompute idle, and tone timing / enable behaviour.
// Expected results are queued at stimulus time and popped on each upd_o pulse.
module tb_buzzer_tone_gen;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [3:0]  sel_i;
  logic        en_i;
  logic        buzzer_o;
  logic [21:0] cmp_freq_o;
  logic [10:0] freq_hz_o;
  logic [19:0] freq_bcd_o;
  logic        busy_o;
  logic        upd_o;
`ifdef BUZZER_MUTE_EN
  logic        mute_i = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  sel;
    int          exp_cmp;
    int          exp_hz;
    logic [19:0] exp_bcd;
  } vec_t;

  typedef struct {
    int          cmp;
    int          hz;
    logic [19:0] bcd;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[7];

  buzzer_tone_gen dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .sel_i      (sel_i),
    .en_i       (en_i),
`ifdef BUZZER_MUTE_EN
    .mute_i     (mute_i),
`endif
    .buzzer_o   (buzzer_o),
    .cmp_freq_o (cmp_freq_o),
    .freq_hz_o  (freq_hz_o),
    .freq_bcd_o (freq_bcd_o),
    .busy_o     (busy_o),
    .upd_o      (upd_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic push_exp(input int cmp, input int hz, input logic [19:0] bcd);
    exp_t e;
    e.cmp = cmp;
    e.hz  = hz;
    e.bcd = bcd;
    sb_q.push_back(e);
  endtask

  // Call right after the capture edge; waits for upd_o and scores latency, busy length and values.
  task automatic wait_upd(input string nm);
    int  n;
    int  busy_n;
    bit  got;
    exp_t e;
    n = 0;
    busy_n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      #1;
      if (busy_o) busy_n++;
      if (upd_o) got = 1'b1;
      else begin
        @(posedge clk_i);
        n++;
      end
    end
    chk({nm, "_latency"}, n, 44);
    chk({nm, "_busy_cycles"}, busy_n, 43);
    if (got) begin
      if (sb_q.size() == 0) begin
        chk({nm, "_sb_nonempty"}, 0, 1);
      end else begin
        e = sb_q.pop_front();
        chk({nm, "_cmp"}, cmp_freq_o, e.cmp);
        chk({nm, "_hz"}, freq_hz_o, e.hz);
        chk({nm, "_bcd"}, freq_bcd_o, e.bcd);
        chk({nm, "_buzz_restart"}, buzzer_o, 0);
      end
    end
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_buzzer"}, buzzer_o, 0);
    chk({nm, "_cmp"}, cmp_freq_o, 0);
    chk({nm, "_hz"}, freq_hz_o, 0);
    chk({nm, "_bcd"}, freq_bcd_o, 0);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_upd"}, upd_o, 0);
  endtask

  task automatic wait_buzz(input logic lvl, output int n);
    n = 0;
    while (buzzer_o !== lvl && n < 20000) begin
      @(posedge clk_i);
      n++;
      #1;
    end
  endtask

  initial begin
    int n;
    int upd_cnt;

    vecs[0] = '{sel: 4'd0,  exp_cmp: 250000, exp_hz: 100,  exp_bcd: 20'h00100};
    vecs[1] = '{sel: 4'd15, exp_cmp: 15625,  exp_hz: 1600, exp_bcd: 20'h01600};
    vecs[2] = '{sel: 4'd7,  exp_cmp: 31250,  exp_hz: 800,  exp_bcd: 20'h00800};
    vecs[3] = '{sel: 4'd3,  exp_cmp: 62500,  exp_hz: 400,  exp_bcd: 20'h00400};
    vecs[4] = '{sel: 4'd10, exp_cmp: 22727,  exp_hz: 1100, exp_bcd: 20'h01100};
    vecs[5] = '{sel: 4'd1,  exp_cmp: 125000, exp_hz: 200,  exp_bcd: 20'h00200};
    vecs[6] = '{sel: 4'd12, exp_cmp: 19230,  exp_hz: 1300, exp_bcd: 20'h01300};

    rst_n_i = 1'b0;
    sel_i   = 4'd0;
    en_i    = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk_reset_outs("reset");

    // Selector table; entry 0 is the automatic computation after reset release.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      if (i == 0) rst_n_i = 1'b1;
      else sel_i = vecs[i].sel;
      push_exp(vecs[i].exp_cmp, vecs[i].exp_hz, vecs[i].exp_bcd);
      @(posedge clk_i);
      wait_upd($sformatf("vec%0d", i));
    end

    // Unchanged selector must not retrigger.
    upd_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk_i);
      #1;
      if (upd_o || busy_o) upd_cnt++;
    end
    chk("idle_no_recompute", upd_cnt, 0);

    // Selector change mid-divide: first result for 5, then a second for 9.
    @(negedge clk_i);
    sel_i = 4'd5;
    push_exp(41666, 600, 20'h00600);
    @(posedge clk_i);
    fork
      wait_upd("sel5");
      begin
        repeat (10) @(negedge clk_i);
        sel_i = 4'd9;
        push_exp(25000, 1000, 20'h01000);
      end
    join
    @(posedge clk_i);
    wait_upd("sel9");

    // Reset in the middle of a divide: outputs clear, no stale update, fresh run afterwards.
    @(negedge clk_i);
    sel_i = 4'd6;
    @(posedge clk_i);
    repeat (10) @(posedge clk_i);
    #1;
    chk("middiv_busy", busy_o, 1);
    rst_n_i = 1'b0;
    #1;
    chk_reset_outs("middiv_reset");
    sel_i = 4'd15;
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    push_exp(15625, 1600, 20'h01600);
    @(posedge clk_i);
    wait_upd("post_reset");
    chk("sb_drained", sb_q.size(), 0);

    // Tone timing at sel=15, then enable drop and re-raise.
    wait_buzz(1'b1, n);
    chk("first_toggle", n, 15625);
    wait_buzz(1'b0, n);
    chk("half_period", n, 15625);
    wait_buzz(1'b1, n);
    chk("second_rise", n, 15625);
    repeat (100) @(posedge clk_i);
    @(negedge clk_i);
    en_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("en_drop_buzz", buzzer_o, 0);
    repeat (20) @(posedge clk_i);
    #1;
    chk("en_low_hold", buzzer_o, 0);
    @(negedge clk_i);
    en_i = 1'b1;
    wait_buzz(1'b1, n);
    chk("reen_toggle", n, 15625);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
